// File: rtl/control_sequencer_if.sv
// control_sequencer_if: fetch handshake plus decoder/datapath bus of the control sequencer.
//
// Signals:
//   instr_valid, instr_in, instr_ready : instruction fetch valid/ready handshake
//   halt_req                           : stop at the next instruction boundary
//   dec_cw, dec_next_state             : control word and next micro-state from the decoder
//   instruction, state                 : instruction register and micro-state to the decoders
//   control_word                       : gated control word to the datapath
//   halted, fault                      : status (HALT state, sticky step-overrun fault)
//   retired_count, cycle_count         : performance counters (zero unless SEQ_PERF_EN)
//
// Modports: master = sequencer side, slave = environment (memory, decoders, datapath).
interface control_sequencer_if;
    logic        instr_valid;
    logic [31:0] instr_in;
    logic        instr_ready;
    logic        halt_req;
    logic [30:0] dec_cw;
    logic [1:0]  dec_next_state;
    logic [31:0] instruction;
    logic [1:0]  state;
    logic [30:0] control_word;
    logic        halted;
    logic        fault;
    logic [31:0] retired_count;
    logic [31:0] cycle_count;

    modport master (
        input  instr_valid, instr_in, halt_req, dec_cw, dec_next_state,
        output instr_ready, instruction, state, control_word, halted, fault,
               retired_count, cycle_count
    );

    modport slave (
        output instr_valid, instr_in, halt_req, dec_cw, dec_next_state,
        input  instr_ready, instruction, state, control_word, halted, fault,
               retired_count, cycle_count
    );
endinterface

// File: rtl/control_sequencer.sv
// control_sequencer: multi-cycle control sequencer ahead of the per-opcode decoders.
//
// Fetches an instruction over a valid/ready handshake, holds it in the instruction register,
// presents {instruction, state} to the decoders and forwards the decoder's control word to the
// datapath while stepping micro-states until the decoder returns next state 2'b00.
//
// Ports:
//   clock : system clock, rising edge
//   reset : asynchronous, active-high reset
//   bus   : control_sequencer_if.master (fetch handshake, decoder bus, status, counters)
//
// Parameters:
//   MAX_STEPS : EXECUTE cycles allowed per instruction before a fault (1..4)
//   FETCH_CW  : control word issued on the fetch-accept cycle (PC <- PC+4)
//
// Optional feature: define SEQ_PERF_EN to build the cycle and retired-instruction counters;
// otherwise both counter outputs are tied to zero and no counter flops exist.
module control_sequencer #(
    parameter int unsigned MAX_STEPS = 4,
    parameter logic [30:0] FETCH_CW  = 31'h20000000
) (
    input logic                 clock,
    input logic                 reset,
    control_sequencer_if.master bus
);

    typedef enum logic [1:0] {StFetch, StExecute, StHalt} fsm_e;

    localparam logic [2:0] MaxStep = 3'(MAX_STEPS);

    fsm_e        fsm_q;
    logic [31:0] instr_q;
    logic [1:0]  state_q;
    logic [2:0]  step_q;
    logic        fault_q;
    logic        halted_q;

    logic        retire;
    logic [30:0] cw;
    logic        ready;

    assign retire = (fsm_q == StExecute) && (bus.dec_next_state == 2'b00);

    // Handshake and control word depend on same-cycle inputs, so they stay combinational.
    // Reset gates them because the FSM already sits in FETCH while reset is held.
    always_comb begin
        ready = 1'b0;
        cw    = '0;
        if (!reset) begin
            unique case (fsm_q)
                StFetch: begin
                    if (!bus.halt_req) begin
                        ready = 1'b1;
                        if (bus.instr_valid) cw = FETCH_CW;
                    end
                end
                StExecute: cw = bus.dec_cw;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fsm_q    <= StFetch;
            instr_q  <= '0;
            state_q  <= 2'b00;
            step_q   <= '0;
            fault_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            unique case (fsm_q)
                StFetch: begin
                    // halt_req wins over a pending instruction
                    if (bus.halt_req) begin
                        fsm_q    <= StHalt;
                        halted_q <= 1'b1;
                    end else if (bus.instr_valid) begin
                        instr_q <= bus.instr_in;
                        state_q <= 2'b00;
                        step_q  <= 3'd1;
                        fsm_q   <= StExecute;
                    end
                end
                StExecute: begin
                    if (bus.dec_next_state == 2'b00) begin
                        state_q <= 2'b00;
                        fsm_q   <= StFetch;
                    end else if (step_q == MaxStep) begin
                        // Step budget exhausted without retiring: abort, not counted as retired
                        fault_q  <= 1'b1;
                        halted_q <= 1'b1;
                        fsm_q    <= StHalt;
                    end else begin
                        state_q <= bus.dec_next_state;
                        step_q  <= step_q + 3'd1;
                    end
                end
                StHalt: ;
                default: fsm_q <= StFetch;
            endcase
        end
    end

    assign bus.instr_ready  = ready;
    assign bus.control_word = cw;
    assign bus.instruction  = instr_q;
    assign bus.state        = state_q;
    assign bus.halted       = halted_q;
    assign bus.fault        = fault_q;

`ifdef SEQ_PERF_EN
    logic [31:0] cycle_q;
    logic [31:0] retired_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cycle_q   <= '0;
            retired_q <= '0;
        end else begin
            if (fsm_q != StHalt) cycle_q <= cycle_q + 32'd1;
            if (retire) retired_q <= retired_q + 32'd1;
        end
    end

    assign bus.cycle_count   = cycle_q;
    assign bus.retired_count = retired_q;
`else
    logic unused_retire;
    assign unused_retire     = retire;
    assign bus.cycle_count   = '0;
    assign bus.retired_count = '0;
`endif

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: scoreboard bench for control_sequencer.
// The stimulus process drives one cycle of inputs and pushes the hand-computed expected outputs;
// a monitor pops one record per falling edge and compares it with the DUT.
module tb_control_sequencer;

    localparam logic [30:0] Fcw = 31'h20000000;
    localparam logic [30:0] Dcw = 31'h7FFFFFFF;  // decoder noise while not executing

    logic clock = 1'b0;
    logic reset = 1'b1;

    control_sequencer_if bus ();

    control_sequencer #(
        .MAX_STEPS(4),
        .FETCH_CW (31'h20000000)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        string       name;
        logic        ready;
        logic [30:0] cw;
        logic [1:0]  st;
        logic [31:0] instr;
        logic        halted;
        logic        fault;
        logic [31:0] retired;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string n, input string f, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s.%s actual=%h required=%h", n, f, act, req);
        end
    endtask

    function automatic logic [31:0] ret(input int n);
`ifdef SEQ_PERF_EN
        return 32'(n);
`else
        return (n > 0) ? 32'd0 : 32'd0;
`endif
    endfunction

    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk(mon_e.name, "instr_ready", {31'd0, bus.instr_ready}, {31'd0, mon_e.ready});
            chk(mon_e.name, "control_word", {1'b0, bus.control_word}, {1'b0, mon_e.cw});
            chk(mon_e.name, "state", {30'd0, bus.state}, {30'd0, mon_e.st});
            chk(mon_e.name, "instruction", bus.instruction, mon_e.instr);
            chk(mon_e.name, "halted", {31'd0, bus.halted}, {31'd0, mon_e.halted});
            chk(mon_e.name, "fault", {31'd0, bus.fault}, {31'd0, mon_e.fault});
            chk(mon_e.name, "retired_count", bus.retired_count, mon_e.retired);
        end
    end

    task automatic cyc(input string n, input logic rst, input logic v, input logic [31:0] ins,
                       input logic h, input logic [30:0] dcw, input logic [1:0] ns,
                       input logic e_rdy, input logic [30:0] e_cw, input logic [1:0] e_st,
                       input logic [31:0] e_ins, input logic e_hlt, input logic e_flt,
                       input logic [31:0] e_ret);
        exp_t e;
        @(posedge clock);
        #1;
        reset              = rst;
        bus.instr_valid    = v;
        bus.instr_in       = ins;
        bus.halt_req       = h;
        bus.dec_cw         = dcw;
        bus.dec_next_state = ns;
        e = '{name: n, ready: e_rdy, cw: e_cw, st: e_st, instr: e_ins, halted: e_hlt,
              fault: e_flt, retired: e_ret};
        exp_q.push_back(e);
    endtask

    // Assert reset between clock edges and confirm it acts without waiting for an edge.
    task automatic mid_reset();
        @(negedge clock);
        #1;
        reset = 1'b1;
        #1;
        chk("async_reset", "state", {30'd0, bus.state}, 32'd0);
        chk("async_reset", "instruction", bus.instruction, 32'd0);
        chk("async_reset", "control_word", {1'b0, bus.control_word}, 32'd0);
        chk("async_reset", "instr_ready", {31'd0, bus.instr_ready}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.instr_valid    = 1'b0;
        bus.instr_in       = '0;
        bus.halt_req       = 1'b0;
        bus.dec_cw         = Dcw;
        bus.dec_next_state = 2'b01;

        // Reset values
        cyc("rst", 1, 0, 0, 0, Dcw, 2'b01, 0, 0, 0, 0, 0, 0, 0);
        cyc("rst", 1, 1, 32'h1, 0, Dcw, 2'b01, 0, 0, 0, 0, 0, 0, 0);

        // Single-state instruction: 1 FETCH + 1 EXECUTE
        cyc("t2_fetch", 0, 1, 32'hD61F0200, 0, Dcw, 2'b01, 1, Fcw, 0, 0, 0, 0, ret(0));
        cyc("t2_exec", 0, 0, 0, 0, 31'h40FFFE02, 2'b00, 0, 31'h40FFFE02, 0, 32'hD61F0200,
            0, 0, ret(0));
        cyc("t2_back", 0, 0, 0, 0, Dcw, 2'b01, 1, 0, 0, 32'hD61F0200, 0, 0, ret(1));

        // instr_valid low: ready held, no control word leaks from the decoder
        for (int i = 0; i < 4; i++)
            cyc("t3_idle", 0, 0, 32'h55555555, 0, Dcw, 2'b01, 1, 0, 0, 32'hD61F0200, 0, 0,
                ret(1));

        // Three-state instruction 00 -> 01 -> 10 -> retire
        cyc("t4_fetch", 0, 1, 32'h00000013, 0, Dcw, 2'b01, 1, Fcw, 0, 32'hD61F0200, 0, 0, ret(1));
        cyc("t4_s0", 0, 0, 0, 0, 31'h111, 2'b01, 0, 31'h111, 0, 32'h13, 0, 0, ret(1));
        cyc("t4_s1", 0, 0, 0, 0, 31'h222, 2'b10, 0, 31'h222, 1, 32'h13, 0, 0, ret(1));
        cyc("t4_s2", 0, 0, 0, 0, 31'h333, 2'b00, 0, 31'h333, 2, 32'h13, 0, 0, ret(1));
        cyc("t4_done", 0, 0, 0, 0, Dcw, 2'b01, 1, 0, 0, 32'h13, 0, 0, ret(2));

        // halt_req during EXECUTE is ignored until the FETCH boundary
        cyc("t6_fetch", 0, 1, 32'hAAAA5555, 0, Dcw, 2'b01, 1, Fcw, 0, 32'h13, 0, 0, ret(2));
        cyc("t6_s0", 0, 1, 32'h1, 1, 31'h444, 2'b01, 0, 31'h444, 0, 32'hAAAA5555, 0, 0, ret(2));
        cyc("t6_s1", 0, 1, 32'h1, 1, 31'h555, 2'b00, 0, 31'h555, 1, 32'hAAAA5555, 0, 0, ret(2));
        cyc("t6_fetch_hlt", 0, 1, 32'h1, 1, Dcw, 2'b01, 0, 0, 0, 32'hAAAA5555, 0, 0, ret(3));
        cyc("t6_halt", 0, 1, 32'h1, 1, Dcw, 2'b01, 0, 0, 0, 32'hAAAA5555, 1, 0, ret(3));
        cyc("t6_halt_stay", 0, 1, 32'h1, 0, Dcw, 2'b01, 0, 0, 0, 32'hAAAA5555, 1, 0, ret(3));

        // Only reset leaves HALT
        cyc("rst2", 1, 0, 0, 0, Dcw, 2'b01, 0, 0, 0, 0, 0, 0, 0);

        // Step overrun: decoder never returns 00
        cyc("t5_fetch", 0, 1, 32'hFFFF0000, 0, Dcw, 2'b01, 1, Fcw, 0, 0, 0, 0, ret(0));
        cyc("t5_s1", 0, 0, 0, 0, 31'h601, 2'b01, 0, 31'h601, 0, 32'hFFFF0000, 0, 0, ret(0));
        cyc("t5_s2", 0, 0, 0, 0, 31'h602, 2'b01, 0, 31'h602, 1, 32'hFFFF0000, 0, 0, ret(0));
        cyc("t5_s3", 0, 0, 0, 0, 31'h603, 2'b01, 0, 31'h603, 1, 32'hFFFF0000, 0, 0, ret(0));
        cyc("t5_s4", 0, 0, 0, 0, 31'h604, 2'b01, 0, 31'h604, 1, 32'hFFFF0000, 0, 0, ret(0));
        cyc("t5_fault", 0, 1, 32'h9, 0, Dcw, 2'b01, 0, 0, 1, 32'hFFFF0000, 1, 1, ret(0));
        cyc("t5_fault2", 0, 1, 32'h9, 0, Dcw, 2'b01, 0, 0, 1, 32'hFFFF0000, 1, 1, ret(0));

        // Reset mid-EXECUTE with state 01
        cyc("rst3", 1, 0, 0, 0, Dcw, 2'b01, 0, 0, 0, 0, 0, 0, 0);
        cyc("t1_fetch", 0, 1, 32'h12345678, 0, Dcw, 2'b01, 1, Fcw, 0, 0, 0, 0, ret(0));
        cyc("t1_s0", 0, 0, 0, 0, 31'h701, 2'b01, 0, 31'h701, 0, 32'h12345678, 0, 0, ret(0));
        cyc("t1_s1", 0, 0, 0, 0, 31'h702, 2'b01, 0, 31'h702, 1, 32'h12345678, 0, 0, ret(0));
        mid_reset();
        cyc("t1_rst", 1, 1, 32'h3, 0, Dcw, 2'b01, 0, 0, 0, 0, 0, 0, 0);
        cyc("t1_refetch", 0, 1, 32'hCAFE0001, 0, Dcw, 2'b01, 1, Fcw, 0, 0, 0, 0, ret(0));
        cyc("t1_exec", 0, 0, 0, 0, 31'h7, 2'b00, 0, 31'h7, 0, 32'hCAFE0001, 0, 0, ret(0));
        cyc("t1_done", 0, 0, 0, 0, Dcw, 2'b01, 1, 0, 0, 32'hCAFE0001, 0, 0, ret(1));

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clock);
        #1;
        chk("drain", "queue_left", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
